// File: rtl/op_sum_acc.sv
// op_sum_acc: two-stage valid/ready arithmetic pipeline for the RR2 region.
// Stage 1 holds the operands and mode. Stage 2 holds the computed result.
// ADD and SUB are stateless. ACC and CLR_ACC update a persistent accumulator
// and a sticky overflow flag at the moment a transaction moves from S1 to S2.
module op_sum_acc #(
   parameter int WIDTH     = 4,
   parameter int ACC_WIDTH = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [1:0]           mode,
   input  logic [WIDTH-1:0]     dataa,
   input  logic [WIDTH-1:0]     datab,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [ACC_WIDTH-1:0] result,
   output logic                 acc_ovf
);

   typedef enum logic [1:0] {
      MODE_ADD = 2'b00,
      MODE_SUB = 2'b01,
      MODE_ACC = 2'b10,
      MODE_CLR = 2'b11
   } mode_e;

   // Operand sum, zero-extended from WIDTH+1 bits to the result width.
   function automatic logic [ACC_WIDTH-1:0] f_sum_ext(input logic [WIDTH-1:0] a,
                                                       input logic [WIDTH-1:0] b);
      logic [WIDTH:0] s;
      s = {1'b0, a} + {1'b0, b};
      return {{(ACC_WIDTH-WIDTH-1){1'b0}}, s};
   endfunction

   // Operand difference as a WIDTH+1 bit two's-complement value, sign-extended.
   function automatic logic [ACC_WIDTH-1:0] f_diff_ext(input logic [WIDTH-1:0] a,
                                                        input logic [WIDTH-1:0] b);
      logic signed [WIDTH:0] d;
      d = $signed({1'b0, a}) - $signed({1'b0, b});
      return {{(ACC_WIDTH-WIDTH-1){d[WIDTH]}}, d};
   endfunction

   // Accumulator addition with the carry-out kept in the top bit.
   function automatic logic [ACC_WIDTH:0] f_acc_add(input logic [ACC_WIDTH-1:0] acc,
                                                    input logic [ACC_WIDTH-1:0] addend);
      return {1'b0, acc} + {1'b0, addend};
   endfunction

   logic                 s1_valid_q, s1_valid_d;
   logic [WIDTH-1:0]     s1_a_q, s1_a_d;
   logic [WIDTH-1:0]     s1_b_q, s1_b_d;
   mode_e                s1_mode_q, s1_mode_d;

   logic                 s2_valid_q, s2_valid_d;
   logic [ACC_WIDTH-1:0] result_q, result_d;
   logic [ACC_WIDTH-1:0] acc_q, acc_d;
   logic                 acc_ovf_q, acc_ovf_d;

   logic                 s2_load;
   logic                 s1_load;
   logic                 s1_move;
   logic [ACC_WIDTH-1:0] sum_ext;
   logic [ACC_WIDTH:0]   acc_sum;

   // Stall control: a stage loads when it is empty or the stage after it drains.
   always_comb begin
      s2_load = !s2_valid_q || out_ready;
      s1_load = !s1_valid_q || s2_load;
      s1_move = s1_valid_q && s2_load;
   end

   assign in_ready  = s1_load;
   assign out_valid = s2_valid_q;
   assign result    = result_q;
   assign acc_ovf   = acc_ovf_q;

   // S1 next state: capture a new transaction whenever the stage can load.
   always_comb begin
      s1_valid_d = s1_valid_q;
      s1_a_d     = s1_a_q;
      s1_b_d     = s1_b_q;
      s1_mode_d  = s1_mode_q;
      if (s1_load) begin
         s1_valid_d = in_valid;
         if (in_valid) begin
            s1_a_d    = dataa;
            s1_b_d    = datab;
            s1_mode_d = mode_e'(mode);
         end
      end
   end

   // S2 next state: compute the result and update the accumulator on the S1->S2 move.
   always_comb begin
      s2_valid_d = s2_valid_q;
      result_d   = result_q;
      acc_d      = acc_q;
      acc_ovf_d  = acc_ovf_q;
      sum_ext    = f_sum_ext(s1_a_q, s1_b_q);
      acc_sum    = f_acc_add(acc_q, sum_ext);
      if (s2_load) begin
         s2_valid_d = s1_valid_q;
      end
      if (s1_move) begin
         case (s1_mode_q)
            MODE_ADD: result_d = sum_ext;
            MODE_SUB: result_d = f_diff_ext(s1_a_q, s1_b_q);
            MODE_ACC: begin
               acc_d    = acc_sum[ACC_WIDTH-1:0];
               result_d = acc_sum[ACC_WIDTH-1:0];
               if (acc_sum[ACC_WIDTH]) begin
                  acc_ovf_d = 1'b1;
               end
            end
            MODE_CLR: begin
               acc_d     = sum_ext;
               result_d  = sum_ext;
               acc_ovf_d = 1'b0;
            end
            default: result_d = result_q;
         endcase
      end
   end

   // Pipeline and accumulator registers; reset empties both stages and clears all state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid_q <= 1'b0;
         s1_a_q     <= '0;
         s1_b_q     <= '0;
         s1_mode_q  <= MODE_ADD;
         s2_valid_q <= 1'b0;
         result_q   <= '0;
         acc_q      <= '0;
         acc_ovf_q  <= 1'b0;
      end else begin
         s1_valid_q <= s1_valid_d;
         s1_a_q     <= s1_a_d;
         s1_b_q     <= s1_b_d;
         s1_mode_q  <= s1_mode_d;
         s2_valid_q <= s2_valid_d;
         result_q   <= result_d;
         acc_q      <= acc_d;
         acc_ovf_q  <= acc_ovf_d;
      end
   end

endmodule

// File: tb/tb_op_sum_acc.sv
// Bench for op_sum_acc (WIDTH=4, ACC_WIDTH=8): scoreboard of expected results
// pushed on each accepted input and popped on each accepted output.
module tb_op_sum_acc;

   localparam int WIDTH     = 4;
   localparam int ACC_WIDTH = 8;

   localparam logic [1:0] M_ADD = 2'b00;
   localparam logic [1:0] M_SUB = 2'b01;
   localparam logic [1:0] M_ACC = 2'b10;
   localparam logic [1:0] M_CLR = 2'b11;

   logic                 clk;
   logic                 rst_n;
   logic                 in_valid;
   logic                 in_ready;
   logic [1:0]           mode;
   logic [WIDTH-1:0]     dataa;
   logic [WIDTH-1:0]     datab;
   logic                 out_valid;
   logic                 out_ready;
   logic [ACC_WIDTH-1:0] result;
   logic                 acc_ovf;

   op_sum_acc #(.WIDTH(WIDTH), .ACC_WIDTH(ACC_WIDTH)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .mode(mode), .dataa(dataa), .datab(datab), .out_valid(out_valid),
      .out_ready(out_ready), .result(result), .acc_ovf(acc_ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // Scoreboard and reference model state.
   int exp_res_q[$];
   int exp_ovf_q[$];
   int got_q[$];
   int got_ovf_q[$];
   int exp_seq[$];
   int m_acc = 0;
   int m_ovf = 0;

   logic last_ir, last_ov, last_in_fire, last_out_fire;

   task automatic check_val(input string tag, input int obs, input int exp);
      total++;
      if (obs != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic model_push(input logic [1:0] m, input int a, input int b);
      int r;
      int t;
      r = 0;
      case (m)
         M_ADD: r = a + b;
         M_SUB: r = (a - b) & 255;
         M_ACC: begin
            t = m_acc + a + b;
            if (t > 255) m_ovf = 1;
            m_acc = t % 256;
            r = m_acc;
         end
         default: begin
            m_acc = a + b;
            m_ovf = 0;
            r = m_acc;
         end
      endcase
      exp_res_q.push_back(r);
      exp_ovf_q.push_back(m_ovf);
   endtask

   // One clock: drive at posedge+1, evaluate handshakes at negedge.
   task automatic step(input logic v, input logic [1:0] m, input int a, input int b,
                       input logic r);
      int e_res;
      int e_ovf;
      in_valid  = v;
      mode      = m;
      dataa     = WIDTH'(a);
      datab     = WIDTH'(b);
      out_ready = r;
      @(negedge clk);
      last_ir       = in_ready;
      last_ov       = out_valid;
      last_in_fire  = in_valid && in_ready;
      last_out_fire = out_valid && out_ready;
      if (last_out_fire) begin
         if (exp_res_q.size() == 0) begin
            check_val("spurious_out", 1, 0);
         end else begin
            e_res = exp_res_q.pop_front();
            e_ovf = exp_ovf_q.pop_front();
            check_val("sb_result", int'(result), e_res);
            check_val("sb_acc_ovf", int'(acc_ovf), e_ovf);
            got_q.push_back(int'(result));
            got_ovf_q.push_back(int'(acc_ovf));
         end
      end
      if (last_in_fire) model_push(m, a, b);
      @(posedge clk);
      #1;
   endtask

   task automatic drain();
      for (int i = 0; i < 20 && exp_res_q.size() > 0; i++) begin
         step(1'b0, M_ADD, 0, 0, 1'b1);
      end
      check_val("drain_left", exp_res_q.size(), 0);
   endtask

   task automatic expect_seq(input string tag);
      check_val({tag, "_count"}, got_q.size(), exp_seq.size());
      for (int i = 0; i < exp_seq.size() && i < got_q.size(); i++) begin
         check_val($sformatf("%s[%0d]", tag, i), got_q[i], exp_seq[i]);
      end
      got_q.delete();
      got_ovf_q.delete();
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int sent;
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      mode      = M_ADD;
      dataa     = '0;
      datab     = '0;
      out_ready = 1'b0;

      // Reset state
      repeat (3) @(posedge clk);
      #2;
      check_val("rst_out_valid", int'(out_valid), 0);
      check_val("rst_result", int'(result), 0);
      check_val("rst_acc_ovf", int'(acc_ovf), 0);
      #1 rst_n = 1'b1;
      @(posedge clk);
      #1;
      check_val("rst_in_ready", int'(in_ready), 1);

      // ADD 15+15 with latency check
      step(1'b1, M_ADD, 15, 15, 1'b1);
      check_val("lat_accept", int'(last_in_fire), 1);
      step(1'b0, M_ADD, 0, 0, 1'b1);
      check_val("lat_ov_n1", int'(last_ov), 0);
      step(1'b0, M_ADD, 0, 0, 1'b1);
      check_val("lat_ov_n2", int'(last_ov), 1);
      drain();
      exp_seq = '{30};
      expect_seq("add15");

      // SUB both directions, back to back
      step(1'b1, M_SUB, 3, 5, 1'b1);
      step(1'b1, M_SUB, 5, 3, 1'b1);
      drain();
      exp_seq = '{254, 2};
      expect_seq("sub");

      // Accumulate with an interleaved ADD
      step(1'b1, M_CLR, 10, 5, 1'b1);
      step(1'b1, M_ACC, 15, 15, 1'b1);
      step(1'b1, M_ACC, 0, 1, 1'b1);
      step(1'b1, M_ADD, 1, 1, 1'b1);
      step(1'b1, M_ACC, 0, 0, 1'b1);
      drain();
      check_val("acc_ovf_low", int'(acc_ovf), 0);
      exp_seq = '{15, 45, 46, 2, 46};
      expect_seq("acc");

      // Overflow and clear
      step(1'b1, M_CLR, 0, 0, 1'b1);
      for (int i = 0; i < 9; i++) step(1'b1, M_ACC, 15, 15, 1'b1);
      drain();
      check_val("ovf_before_last", got_ovf_q.size() > 9 ? got_ovf_q[8] : -1, 0);
      check_val("ovf_set", got_ovf_q.size() > 9 ? got_ovf_q[9] : -1, 1);
      exp_seq = '{0, 30, 60, 90, 120, 150, 180, 210, 240, 14};
      expect_seq("ovf");
      step(1'b1, M_CLR, 1, 0, 1'b1);
      drain();
      check_val("ovf_cleared", got_ovf_q.size() > 0 ? got_ovf_q[0] : -1, 0);
      exp_seq = '{1};
      expect_seq("clr");

      // Backpressure: capacity of two, held output, ordered release
      step(1'b1, M_ADD, 1, 1, 1'b0);
      check_val("bp_ir0", int'(last_ir), 1);
      step(1'b1, M_ADD, 2, 2, 1'b0);
      check_val("bp_ir1", int'(last_ir), 1);
      step(1'b1, M_ADD, 3, 3, 1'b0);
      check_val("bp_ir2", int'(last_ir), 0);
      step(1'b1, M_ADD, 3, 3, 1'b0);
      check_val("bp_ir3", int'(last_ir), 0);
      check_val("bp_hold_valid", int'(out_valid), 1);
      check_val("bp_hold_result", int'(result), 2);
      step(1'b1, M_ADD, 3, 3, 1'b1);
      check_val("bp_full_accept", int'(last_in_fire), 1);
      check_val("bp_full_out", int'(last_out_fire), 1);
      drain();
      exp_seq = '{2, 4, 6};
      expect_seq("bp");

      // Random stream
      sent = 0;
      for (int i = 0; i < 20000 && sent < 1000; i++) begin
         step(($urandom % 4) != 0, 2'($urandom), int'($urandom % 16), int'($urandom % 16),
              ($urandom % 4) != 0);
         if (last_in_fire) sent++;
      end
      check_val("rand_sent", sent, 1000);
      drain();
      got_q.delete();
      got_ovf_q.delete();

      // Reset mid-operation with sticky overflow and a full pipeline
      step(1'b1, M_CLR, 15, 15, 1'b1);
      for (int i = 0; i < 8; i++) step(1'b1, M_ACC, 15, 15, 1'b1);
      drain();
      check_val("mid_ovf_pre", int'(acc_ovf), 1);
      got_q.delete();
      got_ovf_q.delete();
      step(1'b1, M_ACC, 1, 1, 1'b0);
      step(1'b1, M_ACC, 1, 1, 1'b0);
      step(1'b0, M_ADD, 0, 0, 1'b0);
      check_val("mid_full_valid", int'(out_valid), 1);
      #2 rst_n = 1'b0;
      #1;
      check_val("mid_rst_valid", int'(out_valid), 0);
      check_val("mid_rst_result", int'(result), 0);
      check_val("mid_rst_ovf", int'(acc_ovf), 0);
      exp_res_q.delete();
      exp_ovf_q.delete();
      m_acc = 0;
      m_ovf = 0;
      #3 rst_n = 1'b1;
      #4;
      check_val("mid_in_ready", int'(in_ready), 1);
      step(1'b1, M_ACC, 2, 3, 1'b1);
      drain();
      exp_seq = '{5};
      expect_seq("post_rst");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/op_sum_acc.md
# op_sum_acc

Parametrised, pipelined successor to the registered 4-bit adder used in the RR2 reconfigurable region. It adds or subtracts two WIDTH-bit operands, or accumulates their sum into a running ACC_WIDTH-bit accumulator. Transactions move through a 2-stage valid/ready pipeline with full backpressure. The block is the RR2 arithmetic module for reconfiguration scenarios that need streaming operands and a persistent accumulator.

## Interface
- WIDTH, 4, operand width (>= 2)
- ACC_WIDTH, 8, accumulator and result width (>= WIDTH+2)
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  operand transaction offered
- in_ready  out  1  block accepts transaction this cycle
- mode  in  2  00 ADD, 01 SUB, 10 ACC, 11 CLR_ACC; sampled with operands
- dataa  in  WIDTH  operand A, unsigned
- datab  in  WIDTH  operand B, unsigned
- out_valid  out  1  result available
- out_ready  in  1  downstream accepts result
- result  out  ACC_WIDTH  result of the transaction
- acc_ovf  out  1  sticky accumulator overflow flag

## Operation
- Handshake: a transfer occurs on any edge where valid and ready are both high. Transactions are never dropped, duplicated or reordered.
- Stage 1 (S1) registers dataa, datab, mode and s1_valid.
- Stage 2 (S2) registers the computed result and s2_valid. out_valid = s2_valid.
- Stall rules:
  - s2_load = !s2_valid | out_ready
  - s1_load = !s1_valid | s2_load
  - in_ready = s1_load. This is a combinational path from out_ready.
  - S1 contents move to S2 when s1_valid & s2_load. A stalled stage holds its data.
- Arithmetic is evaluated at the S1→S2 move:
  - ADD: result = zero-extend(dataa + datab), a (WIDTH+1)-bit sum.
  - SUB: result = sign-extend of the (WIDTH+1)-bit two's-complement value dataa − datab.
  - ACC: acc ← acc + dataa + datab, modulo 2^ACC_WIDTH; result = new acc. If the addition carries out of ACC_WIDTH bits, acc_ovf ← 1.
  - CLR_ACC: acc ← zero-extend(dataa + datab); acc_ovf ← 0; result = new acc.
  - ADD and SUB leave acc and acc_ovf unchanged.
- The accumulator updates only on the S1→S2 move, so back-to-back ACC transactions chain correctly with no hazard.
- acc is internal. It is observable only through ACC/CLR_ACC results.
- acc_ovf is sticky. Only CLR_ACC or reset clears it.

## Timing
- Reset (rst_n low, asynchronous):
  - s1_valid = s2_valid = 0, so out_valid = 0.
  - result = 0, acc = 0, acc_ovf = 0.
  - in_ready = 1 as soon as reset is released, because both stages are empty.
- Reset asserted mid-operation discards all in-flight transactions immediately. No partial result is ever presented.
- Latency: 2 cycles. A transaction accepted at edge N is presented with out_valid = 1 after edge N+1 when unstalled.
- Throughput: 1 transaction per cycle while out_ready = 1.
- Capacity: with out_ready held low, the block accepts exactly 2 transactions, then in_ready = 0.
- While out_valid = 1 & out_ready = 0, result and out_valid are held stable.
- Simultaneous events:
  - When the pipeline is full and out_ready = 1, the S2 output, the S1→S2 move and a new input are all accepted on the same edge.
  - acc_ovf changes on the same edge that S2 loads the corresponding ACC/CLR_ACC result.
- Wrap-around: acc wraps modulo 2^ACC_WIDTH and the wrapped value is reported. There is no saturation.

## Test plan
All scenarios use WIDTH=4, ACC_WIDTH=8.
- Basic ADD/SUB, out_ready = 1:
  - ADD 15+15 → result = 0x1E, with out_valid 2 cycles after acceptance.
  - SUB 3−5 → 0xFE.
  - SUB 5−3 → 0x02.
- Accumulate:
  - CLR_ACC 10+5 → 15; ACC 15+15 → 45; ACC 0+1 → 46; acc_ovf = 0.
  - ADD 1+1 → 2 in between leaves the next ACC 0+0 → 46.
- Overflow:
  - CLR_ACC 0+0, then 9 × ACC 15+15 → results 30, 60, …, 240, then 14 (270 mod 256), with acc_ovf = 1 from that beat.
  - A following CLR_ACC 1+0 → result 1, acc_ovf = 0.
- Backpressure: hold out_ready = 0 and offer ADD 1+1, 2+2, 3+3 on consecutive cycles.
  - in_ready drops after 2 accepts.
  - result holds 2.
  - Release out_ready → 2, 4, 6 in order, with no loss or duplication.
- Random stream: 1000 random transactions with random in_valid/out_ready, checked against a scoreboard model including accumulator state. Zero mismatches.
- Reset mid-operation: pipeline full with ACC transactions; pulse rst_n low asynchronously, between edges.
  - out_valid, result and acc_ovf go to 0 immediately; acc = 0.
  - After release, ACC 2+3 → 5.
